// File: rtl/spi_host_shift.sv
// spi_host_shift: byte-level half-duplex 3-wire SPI engine (mode 0).
// Accepts one byte command per valid/ready handshake, shifts it out or in,
// and keeps chip select low across commands until a 'last' byte completes.
// Optional feature: define SPI_HOST_LSB_FIRST_EN to add cmd_lsb_first_i,
// which selects LSB-first shifting per command.
module spi_host_shift #(
  parameter int ClkDivWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [ClkDivWidth-1:0] clkdiv_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [7:0]             cmd_data_i,
  input  logic                   cmd_dir_i,
  input  logic                   cmd_last_i,
`ifdef SPI_HOST_LSB_FIRST_EN
  input  logic                   cmd_lsb_first_i,
`endif
  output logic                   rx_valid_o,
  output logic [7:0]             rx_data_o,
  output logic                   busy_o,
  output logic                   cs_o,
  output logic                   sclk_o,
  output logic                   sdioz_o,
  input  logic                   sdio_i,
  output logic                   sdio_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StWait,
    StHold
  } state_e;

  state_e                 state_q, state_d;
  logic [ClkDivWidth-1:0] cnt_q, cnt_d;
  logic [ClkDivWidth-1:0] div_q, div_d;
  logic [7:0]             data_q, data_d;
  logic [2:0]             idx_q, idx_d;
  logic                   dir_q, dir_d;
  logic                   last_q, last_d;
  logic                   lsb_q, lsb_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   cs_q, cs_d;
  logic                   sclk_q, sclk_d;
  logic                   sdioz_q, sdioz_d;
  logic                   sdio_q, sdio_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  logic                   accept;
  logic                   cmd_lsb_first;
  logic [2:0]             pos_q, pos_d;
  logic                   drive_d;

`ifdef SPI_HOST_LSB_FIRST_EN
  assign cmd_lsb_first = cmd_lsb_first_i;
`else
  assign cmd_lsb_first = 1'b0;
`endif

  assign accept = cmd_valid_i & ready_q;

  // The same bit position serves both transmit and receive: the first bit on
  // the wire is index 7, which maps to data bit 0 when shifting LSB first.
  assign pos_q = lsb_q ? ~idx_q : idx_q;
  assign pos_d = lsb_d ? ~idx_d : idx_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    data_d     = data_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    last_d     = last_q;
    lsb_d      = lsb_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    unique case (state_q)
      StIdle, StWait: begin
        if (accept) begin
          data_d  = cmd_data_i;
          dir_d   = cmd_dir_i;
          last_d  = cmd_last_i;
          lsb_d   = cmd_lsb_first;
          div_d   = clkdiv_i;
          cnt_d   = clkdiv_i;
          idx_d   = 3'd7;
          state_d = StLow;
        end
      end
      StLow: begin
        if (cnt_q == '0) begin
          // Sample on the same edge that raises sclk_o.
          if (dir_q) data_d[pos_q] = sdio_i;
          cnt_d   = div_q;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHigh: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          if (idx_q != 3'd0) begin
            idx_d   = idx_q - 3'd1;
            state_d = StLow;
          end else begin
            if (dir_q) begin
              rx_valid_d = 1'b1;
              rx_data_d  = data_q;
            end
            state_d = last_q ? StHold : StWait;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Pin values are decoded from the next state so the pins come straight
    // from flops and change on the same edge as the state.
    drive_d = ((state_d == StLow) || (state_d == StHigh)) && !dir_d;
    cs_d    = (state_d == StIdle);
    sclk_d  = (state_d == StHigh);
    sdioz_d = !drive_d;
    sdio_d  = drive_d & data_d[pos_d];
    ready_d = (state_d == StIdle) || (state_d == StWait);
    busy_d  = (state_d != StIdle);
  end

  // State, datapath and output registers; reset forces pins idle at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= '0;
      data_q     <= '0;
      idx_q      <= 3'd7;
      dir_q      <= 1'b0;
      last_q     <= 1'b0;
      lsb_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      sdioz_q    <= 1'b1;
      sdio_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      last_q     <= last_d;
      lsb_q      <= lsb_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      sdioz_q    <= sdioz_d;
      sdio_q     <= sdio_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign busy_o      = busy_q;
  assign cs_o        = cs_q;
  assign sclk_o      = sclk_q;
  assign sdioz_o     = sdioz_q;
  assign sdio_o      = sdio_q;

endmodule

// File: doc/spi_host_shift.md
# spi_host_shift

Byte-level serial engine that sits directly downstream of the SPI host core's command/data FIFOs and drives the half-duplex 3-wire SPI pins (`cs_o`, `sclk_o`, `sdio_o`/`sdioz_o`, `sdio_i`). It accepts one byte command at a time over a valid/ready handshake and shifts it out, or shifts a byte in, in SPI mode 0 (CPOL=0, CPHA=0). Read bytes are returned to the core as a one-cycle pulse. Chip select is held low across consecutive commands until a command marked `last` completes.

## Interface

Parameters:
- `ClkDivWidth`, default 8: width of the clock divider input.

Ports:
- `clk_i`, input, 1: system clock.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `clkdiv_i`, input, ClkDivWidth: half SCLK period minus one, in `clk_i` cycles. Captured on command accept.
- `cmd_valid_i`, input, 1: command valid.
- `cmd_ready_o`, output, 1: engine can accept a command.
- `cmd_data_i`, input, 8: byte to transmit. Ignored for reads.
- `cmd_dir_i`, input, 1: 0 = write byte, 1 = read byte.
- `cmd_last_i`, input, 1: release CS after this byte.
- `rx_valid_o`, output, 1: one-cycle pulse, read byte available. No backpressure; the consumer must accept it.
- `rx_data_o`, output, 8: received byte, valid while `rx_valid_o` is high.
- `busy_o`, output, 1: high in any state other than IDLE.
- `cs_o`, output, 1: chip select, active-low.
- `sclk_o`, output, 1: serial clock.
- `sdioz_o`, output, 1: 1 = release the data pad (high-Z).
- `sdio_i`, input, 1: serial data in.
- `sdio_o`, output, 1: serial data out.

## Operation

- D = captured `clkdiv_i` + 1.
- States: IDLE, LOW, HIGH, WAIT, HOLD.

Per-state behaviour:
- **IDLE:** `cs_o`=1, `sclk_o`=0, `sdioz_o`=1, `sdio_o`=0, `cmd_ready_o`=1.
  - On accept (`cmd_valid_i & cmd_ready_o`), capture data, dir, last and D, set bit index to 7, then go to LOW.
- **LOW (D cycles):** `cs_o`=0, `sclk_o`=0.
  - Write: `sdio_o` = current bit, `sdioz_o`=0.
  - Read: `sdioz_o`=1, `sdio_o`=0.
  - At the end of LOW, `sdio_i` is sampled into the shift register on the same edge that raises `sclk_o`; go to HIGH.
- **HIGH (D cycles):** `sclk_o`=1, data unchanged.
  - At the end of HIGH, if bits remain, decrement the index and go to LOW.
  - After bit 0:
    - For a read, pulse `rx_valid_o` for one cycle with `rx_data_o`.
    - Then go to HOLD if last, else to WAIT.
- **WAIT:** `cs_o`=0, `sclk_o`=0, `sdioz_o`=1, `cmd_ready_o`=1.
  - On accept, capture the command and go to LOW. CS is never deasserted between bytes.
- **HOLD (D cycles):** `cs_o`=0, `sclk_o`=0, `sdioz_o`=1; then go to IDLE.
- `cmd_ready_o` is 0 in LOW, HIGH and HOLD.
- `clkdiv_i` changes outside an accept cycle have no effect on the byte in flight.
- Bit order is MSB first (bit 7 first) unless changed by the Configuration option below.
- Reset values: `cs_o`=1, `sclk_o`=0, `sdioz_o`=1, `sdio_o`=0, `cmd_ready_o`=1, `rx_valid_o`=0, `rx_data_o`=0, `busy_o`=0, state IDLE.
- Reset asserted mid-byte immediately forces all outputs to their reset values, with no completion of the byte.

## Timing

- All pin outputs are registered.
- Accept at edge t: `cs_o` falls and LOW starts at t+1.
- One byte = 16·D cycles from LOW entry to the end of the last HIGH.
- `rx_valid_o` is asserted in the first cycle after the last HIGH, at the same time as entry to WAIT or HOLD.
- A command accepted in WAIT starts LOW on the next cycle, so there is exactly 1 cycle of `sclk_o`=0 gap plus the normal LOW.
- From IDLE accept to `cs_o` rising: 1 + 16·D + D cycles after the accept edge. With D=1, `cs_o` is low for 17 cycles.
- The accept edge is the only point where a command is consumed; there is no skid buffer.
- The bit counter is 3 bits and does not wrap within a byte.
- The divider counter is ClkDivWidth bits, counts D−1 down to 0, and reloads on every phase change.

## Configuration

- `SPI_HOST_LSB_FIRST_EN` defined:
  - Adds input `cmd_lsb_first_i` (1 bit), captured on accept.
  - When it is 1, the engine transmits bits 0→7 and places received bits so that the first bit received lands in `rx_data_o[0]`.
- Macro undefined: the port is absent and the engine is MSB first only.

## Test plan

- Write 0xA5, last=1, `clkdiv_i`=0:
  - `sdio_o` at the 8 `sclk_o` rising edges is 1,0,1,0,0,1,0,1.
  - `cs_o` is low for exactly 17 cycles.
  - `sdioz_o` is 0 only during LOW/HIGH.
  - No `rx_valid_o` pulse.
- Read, last=1, `clkdiv_i`=2, device drives 0x3C on `sdio_i` changing on falling `sclk_o`:
  - Exactly one `rx_valid_o` pulse with `rx_data_o`=0x3C, 48 cycles after LOW entry.
  - `sdioz_o`=1 throughout.
- Write 0x9F (last=0) followed by read (last=1), with `cmd_valid_i` held:
  - `cs_o` stays low across both bytes.
  - 1-cycle WAIT gap between the bytes.
  - `cmd_ready_o` is high only in IDLE/WAIT.
- `clkdiv_i` changed from 0 to 5 mid-byte:
  - The current byte keeps D=1.
  - The next accepted byte uses D=6 (96 cycles per byte).
- `rst_ni` asserted during the HIGH phase of bit 4:
  - Outputs return to 1/0/1/0 immediately.
  - A new command after reset starts cleanly at bit 7.
- With `SPI_HOST_LSB_FIRST_EN`, write 0x01 with `cmd_lsb_first_i`=1:
  - `sdio_o` is 1 at the first rising edge, then 0 for the remaining seven edges.
